cnt_pattern_checker: RTL and testbench
======================================

Name: cnt_pattern_checker

Overview:
- Downstream monitor for the team's 3-bit pattern counters (mod-N, up/down bounce, alternating "sandwich" moduli).
- Samples the counter output on a strobe, learns the period boundary and locks to it, then checks every later sample against the expected next value.
- Reports direction/phase, turn and period events, and errors to the surrounding test/status logic.

Parameters:
- W, 3, counter value width.
- CW, 8, width of err_cnt and period_cnt.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  sample strobe; cnt_in is valid when en=1 (tie high for every-cycle counters; drive every 2nd cycle for the divided repeater).
- mode  in  2  0=WRAP, 1=BOUNCE, 2=SANDWICH, 3=reserved.
- lim_a  in  W  WRAP/SANDWICH phase-A max; BOUNCE top.
- lim_b  in  W  SANDWICH phase-B max; unused otherwise.
- cnt_in  in  W  observed counter value.
- locked  out  1  tracking a verified sequence.
- dir  out  1  0=up/phase A, 1=down/phase B; meaningful only when locked.
- turn  out  1  1-cycle pulse on a direction/phase change.
- period_done  out  1  1-cycle pulse at the end of each full period.
- err  out  1  1-cycle pulse on a mismatch.
- err_cnt  out  CW  mismatch count; saturates at all-ones.
- period_cnt  out  CW  completed periods; wraps.
- cfg_bad  out  1  level, combinational from mode/lim_a: mode=3, or BOUNCE with lim_a=0.

Behaviour:
Reset and timing:
- Reset (sync, any time, including mid-TRACK): state=IDLE; prev=0; every registered output 0 on the next edge.
- Only samples with en=1 are processed. Outputs are registered and update on the edge that captures the sample (1-cycle latency). With en=0 all state holds and pulses are 0.
- cfg_bad=1 forces IDLE: locked=0, no pulses, counters hold.
- Configuration is assumed static while locked. A change takes effect on the next sample and is checked like any other sample.

State machine (IDLE, ACQ, TRACK):
- IDLE: first en sample sets prev=cnt_in, then go to ACQ.
- ACQ: each sample checks the boundary pair (prev, cnt_in), then sets prev=cnt_in.
  - WRAP: (lim_a, 0).
  - BOUNCE: (1, 0).
  - SANDWICH: (lim_b, 0).
  - On a match: locked<=1, dir<=0, go to TRACK. No turn or period_done pulse on lock.
- TRACK: compare cnt_in with exp(prev, dir).
  - WRAP: prev==lim_a ? 0 : prev+1.
  - BOUNCE: dir=0 -> prev+1; dir=1 -> prev-1.
  - SANDWICH: dir=0 -> (prev==lim_a ? 0 : prev+1); dir=1 -> (prev==lim_b ? 0 : prev+1).
  - Arithmetic is W-bit, modulo 2^W.
  - A held value (cnt_in==prev) is a mismatch.
- TRACK match: prev<=cnt_in, plus these events:
  - BOUNCE, dir=0, cnt_in==lim_a: dir<=1, turn.
  - BOUNCE, dir=1, cnt_in==0: dir<=0, turn, period_done.
  - SANDWICH, 0 arriving from lim_a (dir=0): dir<=1, turn.
  - SANDWICH, 0 arriving from lim_b (dir=1): dir<=0, turn, period_done.
  - WRAP, 0 arriving from lim_a: period_done only; dir stays 0.
  - period_done increments period_cnt.
- TRACK mismatch: err pulse, err_cnt+1 (saturating), locked<=0, prev<=cnt_in, go to ACQ.
  - The mismatching sample can itself be the 2nd element of the next boundary pair.
- Edge cases:
  - WRAP with lim_a=0 is legal (constant 0 stream).
  - SANDWICH with lim_a==lim_b behaves as WRAP with turns.

Decomposition:
- Package cnt_chk_pkg holds:
  - mode_e (WRAP, BOUNCE, SANDWICH, RSVD).
  - state_e (IDLE, ACQ, TRACK).
  - The pure function exp_next(mode, dir, prev, lim_a, lim_b).
  - The boundary-pair predicate is_boundary(mode, prev, cur, lim_a, lim_b).
- One combinational sub-module, cnt_next_model, wraps these. It outputs exp, will_turn and will_end and is reusable as a bench reference model.

Test Plan:
- WRAP lim_a=4, en=1, stream 0,1,2,3,4,0,1…:
  - locked=1 after the first 4->0.
  - period_done on each later 4->0, period_cnt increments.
  - err_cnt stays 0.
- BOUNCE lim_a=7, cnt changing every 2nd cycle, en every 2nd cycle:
  - lock at 1->0.
  - turn at 7 (dir->1) and at 0 (dir->0, period_done).
  - No err on the non-en cycles.
- SANDWICH lim_a=4 lim_b=7, stream 0..4,0..7 repeating:
  - lock on 7->0.
  - turn at each 4->0 and 7->0.
  - period_done only on 7->0.
- WRAP lim_a=4, stream …3,4,0,1,3,4,0:
  - err pulse on the edge capturing the 3, err_cnt=1, locked=0.
  - relock on the next 4->0, with no extra err.
- Errors and saturation:
  - Constant cnt_in=2 in WRAP after lock: a single err, after which the block stays in ACQ with no further errors.
  - Alternating stream 0,4,0,4,… (relock on each 4->0, fail on each 0->4), run for 300 mismatches: err_cnt=255 and holds.
- rst for 1 cycle mid-TRACK: all outputs 0 next edge. mode=3: cfg_bad=1, locked stays 0, no pulses for any stream.

Source files
------------

// File: rtl/cnt_chk_pkg.sv
// Shared types and pure next-value / boundary rules for the pattern-counter checker.
// Both the RTL and any reference model can call these functions.
package cnt_chk_pkg;

    localparam int CNT_W = 3;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        WRAP     = 2'd0,
        BOUNCE   = 2'd1,
        SANDWICH = 2'd2,
        RSVD     = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } state_e;

    // Expected successor of prev; all arithmetic wraps modulo 2^CNT_W.
    function automatic cnt_t exp_next(mode_e mode, logic dir, cnt_t prev, cnt_t lim_a, cnt_t lim_b);
        cnt_t top;
        top = (mode == SANDWICH && dir) ? lim_b : lim_a;
        case (mode)
            BOUNCE:         exp_next = dir ? prev - cnt_t'(1) : prev + cnt_t'(1);
            WRAP, SANDWICH: exp_next = (prev == top) ? '0 : prev + cnt_t'(1);
            default:        exp_next = prev;
        endcase
    endfunction

    // The (prev, cur) pair that marks the start of a period and allows locking.
    function automatic logic is_boundary(mode_e mode, cnt_t prev, cnt_t cur, cnt_t lim_a, cnt_t lim_b);
        case (mode)
            WRAP:     is_boundary = (prev == lim_a)    && (cur == '0);
            BOUNCE:   is_boundary = (prev == cnt_t'(1)) && (cur == '0);
            SANDWICH: is_boundary = (prev == lim_b)    && (cur == '0);
            default:  is_boundary = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cnt_next_model.sv
// Combinational next-value model: expected value after prev, plus whether the
// matching step turns direction/phase and whether it closes a period.
module cnt_next_model
    import cnt_chk_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  mode_e          mode,
    input  logic           dir,
    input  logic [W-1:0]   prev,
    input  logic [W-1:0]   lim_a,
    input  logic [W-1:0]   lim_b,
    output logic [W-1:0]   exp,
    output logic           will_turn,
    output logic           will_end
);

    logic [W-1:0] top;

    always_comb begin
        exp       = exp_next(mode, dir, prev, lim_a, lim_b);
        top       = (mode == SANDWICH && dir) ? lim_b : lim_a;
        will_turn = 1'b0;
        will_end  = 1'b0;
        case (mode)
            WRAP: will_end = (prev == lim_a);
            BOUNCE: begin
                will_turn = dir ? (exp == '0) : (exp == lim_a);
                will_end  = dir && (exp == '0);
            end
            // A 0 arriving from the active phase maximum flips phase; only phase B closes a period.
            SANDWICH: begin
                will_turn = (prev == top);
                will_end  = dir && (prev == top);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cnt_pattern_checker.sv
// Monitor for 3-bit pattern counters: acquires the period boundary, locks,
// then checks every strobed sample and reports turn/period/error events.
module cnt_pattern_checker
    import cnt_chk_pkg::*;
#(
    parameter int W  = CNT_W,
    parameter int CW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [1:0]     mode,
    input  logic [W-1:0]   lim_a,
    input  logic [W-1:0]   lim_b,
    input  logic [W-1:0]   cnt_in,
    output logic           locked,
    output logic           dir,
    output logic           turn,
    output logic           period_done,
    output logic           err,
    output logic [CW-1:0]  err_cnt,
    output logic [CW-1:0]  period_cnt,
    output logic           cfg_bad
);

    state_e        state_reg, state_next;
    logic [W-1:0]  prev_reg, prev_next;
    logic          dir_reg, dir_next;
    logic          locked_reg, locked_next;
    logic          turn_reg, turn_next;
    logic          pd_reg, pd_next;
    logic          err_reg, err_next;
    logic [CW-1:0] err_cnt_reg, err_cnt_next;
    logic [CW-1:0] period_cnt_reg, period_cnt_next;

    mode_e         mode_q;
    logic [W-1:0]  exp_val;
    logic          will_turn;
    logic          will_end;

    assign mode_q  = mode_e'(mode);
    assign cfg_bad = (mode_q == RSVD) || (mode_q == BOUNCE && lim_a == '0);

    cnt_next_model #(.W(W)) u_next (
        .mode      (mode_q),
        .dir       (dir_reg),
        .prev      (prev_reg),
        .lim_a     (lim_a),
        .lim_b     (lim_b),
        .exp       (exp_val),
        .will_turn (will_turn),
        .will_end  (will_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            prev_reg       <= '0;
            dir_reg        <= 1'b0;
            locked_reg     <= 1'b0;
            turn_reg       <= 1'b0;
            pd_reg         <= 1'b0;
            err_reg        <= 1'b0;
            err_cnt_reg    <= '0;
            period_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            prev_reg       <= prev_next;
            dir_reg        <= dir_next;
            locked_reg     <= locked_next;
            turn_reg       <= turn_next;
            pd_reg         <= pd_next;
            err_reg        <= err_next;
            err_cnt_reg    <= err_cnt_next;
            period_cnt_reg <= period_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        prev_next       = prev_reg;
        dir_next        = dir_reg;
        locked_next     = locked_reg;
        turn_next       = 1'b0;
        pd_next         = 1'b0;
        err_next        = 1'b0;
        err_cnt_next    = err_cnt_reg;
        period_cnt_next = period_cnt_reg;

        // A bad configuration parks the checker regardless of the strobe.
        if (cfg_bad) begin
            state_next  = IDLE;
            locked_next = 1'b0;
        end else if (en) begin
            prev_next = cnt_in;
            case (state_reg)
                IDLE: state_next = ACQ;
                ACQ: begin
                    if (is_boundary(mode_q, prev_reg, cnt_in, lim_a, lim_b)) begin
                        locked_next = 1'b1;
                        dir_next    = 1'b0;
                        state_next  = TRACK;
                    end
                end
                TRACK: begin
                    if (cnt_in == exp_val) begin
                        if (will_turn) begin
                            dir_next  = ~dir_reg;
                            turn_next = 1'b1;
                        end
                        if (will_end) begin
                            pd_next         = 1'b1;
                            period_cnt_next = period_cnt_reg + CW'(1);
                        end
                    end else begin
                        // The offending sample stays in prev so it can open the next boundary pair.
                        err_next    = 1'b1;
                        locked_next = 1'b0;
                        state_next  = ACQ;
                        if (err_cnt_reg != '1)
                            err_cnt_next = err_cnt_reg + CW'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign locked      = locked_reg;
    assign dir         = dir_reg;
    assign turn        = turn_reg;
    assign period_done = pd_reg;
    assign err         = err_reg;
    assign err_cnt     = err_cnt_reg;
    assign period_cnt  = period_cnt_reg;

endmodule

// File: tb/tb_cnt_pattern_checker.sv
// Bench for cnt_pattern_checker: fixed vector table, directed multi-cycle
// sequences and randomized streams, all checked against an arithmetic model.
module tb_cnt_pattern_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [2:0] lim_a = 3'd0, lim_b = 3'd0, cnt_in = 3'd0;
    logic       locked, dir, turn, period_done, err, cfg_bad;
    logic [7:0] err_cnt, period_cnt;

    int tests = 0;
    int fails = 0;

    // Behavioural model state.
    int m_have = 0, m_locked = 0, m_dir = 0, m_prev = 0;
    int m_ec = 0, m_pc = 0, m_turn = 0, m_pd = 0, m_err = 0;

    always #5 clk = ~clk;

    cnt_pattern_checker #(.W(3), .CW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .lim_a       (lim_a),
        .lim_b       (lim_b),
        .cnt_in      (cnt_in),
        .locked      (locked),
        .dir         (dir),
        .turn        (turn),
        .period_done (period_done),
        .err         (err),
        .err_cnt     (err_cnt),
        .period_cnt  (period_cnt),
        .cfg_bad     (cfg_bad)
    );

    typedef struct {
        logic       rst, en;
        logic [1:0] mode;
        logic [2:0] la, lb, cnt;
        logic       locked, turn, pd, err, cfg_bad;
        int         ec, pc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic e, logic [1:0] m, logic [2:0] a, logic [2:0] b, logic [2:0] c,
                                logic l, logic t, logic p, logic x, logic cb, int ec, int pc);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.la = a; v.lb = b; v.cnt = c;
        v.locked = l; v.turn = t; v.pd = p; v.err = x; v.cfg_bad = cb; v.ec = ec; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: rules applied directly with integer arithmetic modulo 8.
    task automatic model_step(input int r, input int e, input int m, input int a, input int b, input int c);
        int t, nxt, bad;
        m_turn = 0; m_pd = 0; m_err = 0;
        bad = (m == 3 || (m == 1 && a == 0)) ? 1 : 0;
        if (r != 0) begin
            m_have = 0; m_locked = 0; m_dir = 0; m_prev = 0; m_ec = 0; m_pc = 0;
        end else if (bad != 0) begin
            m_have = 0; m_locked = 0;
        end else if (e != 0) begin
            if (m_have == 0) begin
                m_have = 1;
            end else if (m_locked == 0) begin
                t = (m == 0) ? a : (m == 1) ? 1 : b;
                if (m_prev == t && c == 0) begin
                    m_locked = 1; m_dir = 0;
                end
            end else begin
                t = (m == 2 && m_dir == 1) ? b : a;
                if (m == 1) nxt = (m_prev + ((m_dir == 1) ? 7 : 1)) % 8;
                else        nxt = (m_prev == t) ? 0 : (m_prev + 1) % 8;
                if (c == nxt) begin
                    if (m == 1) begin
                        if (m_dir == 0 && c == a) begin
                            m_dir = 1; m_turn = 1;
                        end else if (m_dir == 1 && c == 0) begin
                            m_dir = 0; m_turn = 1; m_pd = 1;
                        end
                    end else if (m == 2) begin
                        if (m_prev == t) begin
                            m_turn = 1; m_pd = m_dir; m_dir = 1 - m_dir;
                        end
                    end else if (m_prev == a) begin
                        m_pd = 1;
                    end
                end else begin
                    m_err = 1; m_locked = 0;
                    if (m_ec < 255) m_ec++;
                end
            end
            m_prev = c;
        end
        if (m_pd != 0) m_pc = (m_pc + 1) % 256;
    endtask

    task automatic apply(input logic r, input logic e, input logic [1:0] m,
                         input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        int bad;
        rst = r; en = e; mode = m; lim_a = a; lim_b = b; cnt_in = c;
        @(posedge clk);
        #1;
        model_step(int'(r), int'(e), int'(m), int'(a), int'(b), int'(c));
        bad = (m == 2'd3 || (m == 2'd1 && a == 3'd0)) ? 1 : 0;
        chk("locked", locked, m_locked);
        if (m_locked != 0) chk("dir", dir, m_dir);
        chk("turn", turn, m_turn);
        chk("period_done", period_done, m_pd);
        chk("err", err, m_err);
        chk("err_cnt", err_cnt, m_ec);
        chk("period_cnt", period_cnt, m_pc);
        chk("cfg_bad", cfg_bad, bad);
        $display("[TB] t=%0t rst=%0b en=%0b mode=%0d la=%0d lb=%0d cnt=%0d -> locked=%0b dir=%0b turn=%0b pd=%0b err=%0b err_cnt=%0d period_cnt=%0d",
                 $time, r, e, m, a, b, c, locked, dir, turn, period_done, err, err_cnt, period_cnt);
    endtask

    initial begin
        int errs, prevv, prev_locked, idx;
        int bt[14];
        int st[13];
        int per[$];

        // ---- table-driven vectors ----
        vq.push_back(mk(1,1,0,4,0,0, 0,0,0,0,0, 0,0));
        vq.push_back(mk(0,1,0,4,0,0, 0,0,0,0,0, 0,0));
        vq.push_back(mk(0,1,0,4,0,1, 0,0,0,0,0, 0,0));
        vq.push_back(mk(0,1,0,4,0,2, 0,0,0,0,0, 0,0));
        vq.push_back(mk(0,1,0,4,0,3, 0,0,0,0,0, 0,0));
        vq.push_back(mk(0,1,0,4,0,4, 0,0,0,0,0, 0,0));
        vq.push_back(mk(0,1,0,4,0,0, 1,0,0,0,0, 0,0));
        vq.push_back(mk(0,1,0,4,0,1, 1,0,0,0,0, 0,0));
        vq.push_back(mk(0,1,0,4,0,2, 1,0,0,0,0, 0,0));
        vq.push_back(mk(0,1,0,4,0,3, 1,0,0,0,0, 0,0));
        vq.push_back(mk(0,1,0,4,0,4, 1,0,0,0,0, 0,0));
        vq.push_back(mk(0,1,0,4,0,0, 1,0,1,0,0, 0,1));
        vq.push_back(mk(0,1,0,4,0,1, 1,0,0,0,0, 0,1));
        vq.push_back(mk(0,1,0,4,0,3, 0,0,0,1,0, 1,1));
        vq.push_back(mk(0,1,0,4,0,4, 0,0,0,0,0, 1,1));
        vq.push_back(mk(0,1,0,4,0,0, 1,0,0,0,0, 1,1));
        vq.push_back(mk(0,1,0,4,0,1, 1,0,0,0,0, 1,1));
        vq.push_back(mk(0,0,0,4,0,6, 1,0,0,0,0, 1,1));
        vq.push_back(mk(0,1,0,4,0,2, 1,0,0,0,0, 1,1));
        vq.push_back(mk(1,1,0,4,0,3, 0,0,0,0,0, 0,0));
        vq.push_back(mk(0,0,0,4,0,5, 0,0,0,0,0, 0,0));
        vq.push_back(mk(0,1,3,4,0,4, 0,0,0,0,1, 0,0));
        vq.push_back(mk(0,1,3,4,0,0, 0,0,0,0,1, 0,0));
        vq.push_back(mk(0,1,1,0,0,1, 0,0,0,0,1, 0,0));
        vq.push_back(mk(0,1,1,0,0,0, 0,0,0,0,1, 0,0));

        foreach (vq[i]) begin
            apply(vq[i].rst, vq[i].en, vq[i].mode, vq[i].la, vq[i].lb, vq[i].cnt);
            chk($sformatf("vec%0d_locked", i), locked, vq[i].locked);
            chk($sformatf("vec%0d_turn", i), turn, vq[i].turn);
            chk($sformatf("vec%0d_pd", i), period_done, vq[i].pd);
            chk($sformatf("vec%0d_err", i), err, vq[i].err);
            chk($sformatf("vec%0d_cfg_bad", i), cfg_bad, vq[i].cfg_bad);
            chk($sformatf("vec%0d_err_cnt", i), err_cnt, vq[i].ec);
            chk($sformatf("vec%0d_period_cnt", i), period_cnt, vq[i].pc);
        end

        // ---- BOUNCE lim_a=7, strobe every 2nd cycle ----
        for (int k = 0; k < 8; k++) bt[k] = k;
        for (int k = 8; k < 14; k++) bt[k] = 14 - k;
        apply(1, 0, 1, 7, 0, 0);
        errs = 0; prevv = -1; prev_locked = 0; idx = 3;
        for (int k = 0; k < 60; k++) begin
            apply(0, 1, 1, 7, 0, 3'(bt[idx % 14]));
            if (err) errs++;
            if (prev_locked == 0 && locked) begin
                chk("bounce_lock_prev", prevv, 1);
                chk("bounce_lock_cur", bt[idx % 14], 0);
                chk("bounce_lock_quiet", {turn, period_done}, 0);
            end else if (prev_locked != 0 && bt[idx % 14] == 7) begin
                chk("bounce_turn_top", {turn, dir, period_done}, 3'b110);
            end else if (prev_locked != 0 && bt[idx % 14] == 0) begin
                chk("bounce_turn_bottom", {turn, dir, period_done}, 3'b101);
            end
            prevv = bt[idx % 14];
            prev_locked = int'(locked);
            idx++;
            apply(0, 0, 1, 7, 0, 3'($urandom_range(0, 7)));
            chk("bounce_idle_pulses", {turn, period_done, err}, 0);
        end
        chk("bounce_errs", errs, 0);
        chk("bounce_periods", period_cnt, 3);

        // ---- SANDWICH lim_a=4 lim_b=7 ----
        for (int k = 0; k < 5; k++) st[k] = k;
        for (int k = 5; k < 13; k++) st[k] = k - 5;
        apply(1, 0, 2, 4, 7, 0);
        prevv = -1; prev_locked = 0; idx = 2; errs = 0;
        for (int k = 0; k < 50; k++) begin
            apply(0, 1, 2, 4, 7, 3'(st[idx % 13]));
            if (err) errs++;
            if (prev_locked == 0 && locked) begin
                chk("sw_lock_prev", prevv, 7);
            end else if (prev_locked != 0 && st[idx % 13] == 0) begin
                chk("sw_turn", turn, 1);
                chk("sw_pd", period_done, (prevv == 7) ? 1 : 0);
            end else if (prev_locked != 0) begin
                chk("sw_quiet", {turn, period_done}, 0);
            end
            prevv = st[idx % 13];
            prev_locked = int'(locked);
            idx++;
        end
        chk("sw_errs", errs, 0);

        // ---- constant value after lock: one error, then silent ACQ ----
        apply(1, 0, 0, 4, 0, 0);
        apply(0, 1, 0, 4, 0, 3);
        apply(0, 1, 0, 4, 0, 4);
        apply(0, 1, 0, 4, 0, 0);
        apply(0, 1, 0, 4, 0, 1);
        errs = 0;
        for (int k = 0; k < 9; k++) begin
            apply(0, 1, 0, 4, 0, 2);
            if (err) errs++;
        end
        chk("const_err_pulses", errs, 1);
        chk("const_locked", locked, 0);
        chk("const_err_cnt", err_cnt, 1);

        // ---- WRAP lim_a=0: constant 0 stream is legal ----
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0);
        chk("wrap0_lock", {locked, period_done}, 2'b10);
        apply(0, 1, 0, 0, 0, 0);
        chk("wrap0_period", {locked, period_done, err}, 3'b110);

        // ---- err_cnt saturation ----
        apply(1, 0, 0, 4, 0, 0);
        apply(0, 1, 0, 4, 0, 4);
        errs = 0;
        for (int k = 0; k < 300; k++) begin
            apply(0, 1, 0, 4, 0, 0);
            apply(0, 1, 0, 4, 0, 4);
            if (err) errs++;
        end
        chk("sat_err_pulses", errs, 300);
        chk("sat_err_cnt", err_cnt, 255);
        apply(0, 1, 0, 4, 0, 0);
        apply(0, 1, 0, 4, 0, 4);
        chk("sat_hold", {err, err_cnt}, {1'b1, 8'd255});

        // ---- randomized streams against the model ----
        for (int c = 0; c < 8; c++) begin
            int m, a, b, len;
            m = (c < 6) ? (c % 3) : int'($urandom_range(0, 3));
            a = int'($urandom_range(0, 7));
            b = int'($urandom_range(0, 7));
            per.delete();
            for (int k = 0; k <= a; k++) per.push_back(k);
            if (m == 1) for (int k = a - 1; k >= 1; k--) per.push_back(k);
            if (m == 2) for (int k = 0; k <= b; k++) per.push_back(k);
            len = per.size();
            idx = int'($urandom_range(0, 15));
            apply(1, 0, 2'(m), 3'(a), 3'(b), 0);
            for (int k = 0; k < 180; k++) begin
                logic e;
                logic [2:0] v;
                e = ($urandom_range(0, 3) != 0);
                v = 3'($urandom_range(0, 7));
                if (e && $urandom_range(0, 11) != 0) v = 3'(per[idx % len]);
                if (e) idx++;
                apply(($urandom_range(0, 149) == 0), e, 2'(m), 3'(a), 3'(b), v);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
